// File: rtl/vga_capture_sequencer.sv
// Gates the VGA pixel logger to whole frames (optional leading skip) and tracks raster x/y.
// output_enable rises one clock after the detecting vsync edge; no backpressure, syncs free-run.
module vga_capture_sequencer #(
  parameter int C_SYNC_ACTIVE       = 0,
  parameter int C_FRAME_COUNT_WIDTH = 8,
  parameter int C_COORD_WIDTH       = 11
) (
  input  logic                           pixel_clk,
  input  logic                           reset_n,
  input  logic                           hsync,
  input  logic                           vsync,
  input  logic                           start,
  input  logic                           abort,
  input  logic [C_FRAME_COUNT_WIDTH-1:0] frame_count,
  input  logic [C_FRAME_COUNT_WIDTH-1:0] skip_frames,
  output logic                           output_enable,
  output logic                           busy,
  output logic                           done,
  output logic [C_FRAME_COUNT_WIDTH-1:0] frame_index,
  output logic [C_COORD_WIDTH-1:0]       x,
  output logic [C_COORD_WIDTH-1:0]       y
);

  localparam int FW = C_FRAME_COUNT_WIDTH;
  localparam int CW = C_COORD_WIDTH;
  localparam logic SYNC_ON = (C_SYNC_ACTIVE != 0);
  localparam logic [FW-1:0] FC_ONE = {{(FW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CO_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CO_MAX = {CW{1'b1}};

  typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DONE} state_t;

  state_t          state_q, state_d;
  logic            hsync_q, vsync_q;
  logic            hs_edge, vs_edge;
  logic            oe_q;
  logic [FW-1:0]   frames_left_q, frames_left_d;
  logic [FW-1:0]   skip_left_q, skip_left_d;
  logic [FW-1:0]   frame_index_q, frame_index_d;
  logic [CW-1:0]   x_q, x_d, y_q, y_d;

  assign hs_edge = (hsync == SYNC_ON) && (hsync_q != SYNC_ON);
  assign vs_edge = (vsync == SYNC_ON) && (vsync_q != SYNC_ON);

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      hsync_q       <= ~SYNC_ON;
      vsync_q       <= ~SYNC_ON;
      oe_q          <= 1'b0;
      frames_left_q <= '0;
      skip_left_q   <= '0;
      frame_index_q <= '0;
      x_q           <= '0;
      y_q           <= '0;
    end else begin
      state_q       <= state_d;
      hsync_q       <= hsync;
      vsync_q       <= vsync;
      oe_q          <= (state_d == CAPTURE);
      frames_left_q <= frames_left_d;
      skip_left_q   <= skip_left_d;
      frame_index_q <= frame_index_d;
      x_q           <= x_d;
      y_q           <= y_d;
    end
  end

  // Raster counters run regardless of capture state; vsync edge dominates hsync for y.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (hs_edge) begin
      x_d = '0;
    end else if (x_q != CO_MAX) begin
      x_d = x_q + CO_ONE;
    end
    if (vs_edge) begin
      y_d = '0;
    end else if (hs_edge && (y_q != CO_MAX)) begin
      y_d = y_q + CO_ONE;
    end
  end

  always_comb begin
    state_d       = state_q;
    frames_left_d = frames_left_q;
    skip_left_d   = skip_left_q;
    frame_index_d = frame_index_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          frames_left_d = frame_count;
          skip_left_d   = skip_frames;
          frame_index_d = '0;
          state_d       = ARM;
        end
      end
      ARM: begin
        // A zero frame request is resolved from the latched copy, one cycle after start.
        if (abort) begin
          state_d = IDLE;
        end else if (frames_left_q == '0) begin
          state_d = DONE;
        end else if (vs_edge) begin
          if (skip_left_q != '0) begin
            skip_left_d = skip_left_q - FC_ONE;
          end else begin
            frame_index_d = '0;
            state_d       = CAPTURE;
          end
        end
      end
      CAPTURE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (vs_edge) begin
          frames_left_d = frames_left_q - FC_ONE;
          if (frames_left_q == FC_ONE) begin
            state_d = DONE;
          end else begin
            frame_index_d = frame_index_q + FC_ONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign output_enable = oe_q;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign frame_index   = frame_index_q;
  assign x             = x_q;
  assign y             = y_q;

endmodule
